// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the configurable UART transmitter: parity modes,
//   serialiser state encodings, the minimum data field width and a helper
//   that maps the raw 3-bit parity configuration onto a parity mode.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;
    localparam logic [2:0] ST_BREAK  = 3'd6;

    localparam int DATA_BITS_MIN = 5;

    // Codes 5..7 are reserved and behave as "no parity".
    function automatic parity_e decode_parity(input logic [2:0] code);
        parity_e p;
        case (code)
            3'd1:    p = PAR_EVEN;
            3'd2:    p = PAR_ODD;
            3'd3:    p = PAR_MARK;
            3'd4:    p = PAR_SPACE;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock FIFO with registered occupancy and status flags.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     flush      empties the FIFO; wins over a simultaneous push
//     push       write request, ignored while full
//     push_data  word to write
//     pop        read request, ignored while empty
//     pop_data   head-of-queue word (combinational read)
//     level      entries held
//     empty/full status flags
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_next;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_push && !do_pop)
            level_next = level + 1'b1;
        else if (!do_push && do_pop)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg
//   UART transmitter with a TX FIFO and runtime frame format (5..MAX_DATA_WIDTH
//   data bits, none/even/odd/mark/space parity, 1 or 2 stop bits, break).
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     baud_en          one-cycle bit-period tick; all line changes happen on it
//     in_data/valid    push side; in_ready = !fifo_full
//     cfg_*            frame format, sampled when a word is popped
//     tx_flush         discard queued words (current frame continues)
//     tx               serial line, idle high
//     tx_busy          frame or break in progress
//     tx_done          one-cycle pulse as the last stop bit ends
//     fifo_level/empty/full  FIFO status
//
//   state     | meaning
//   ST_IDLE   | line marking, waiting for a word or break
//   ST_START  | start bit on the line
//   ST_DATA   | data bit cnt on the line
//   ST_PARITY | parity bit on the line
//   ST_STOP1  | first stop bit on the line
//   ST_STOP2  | second stop bit on the line
//   ST_BREAK  | line held low while cfg_break is high
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_en,
    input  logic [MAX_DATA_WIDTH-1:0]     in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [2:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          cfg_break,
    input  logic                          tx_flush,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full
);

    logic [2:0]                state;
    logic [MAX_DATA_WIDTH-1:0] frame_data;
    logic [3:0]                frame_bits;
    logic                      frame_par_en;
    logic                      frame_par_bit;
    logic                      frame_stop2;
    logic [3:0]                cnt;

    logic [MAX_DATA_WIDTH-1:0] fifo_data;
    logic                      fifo_pop;
    logic [3:0]                cfg_n;
    logic                      data_xor;
    parity_e                   cfg_par;
    logic                      cfg_par_en;
    logic                      cfg_par_bit;
    logic                      at_boundary;
    logic                      can_start;

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (tx_flush),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign in_ready = !fifo_full;
    assign tx_busy  = (state != ST_IDLE);

    always_comb begin
        cfg_n = cfg_data_bits;
        if (cfg_data_bits < 4'(DATA_BITS_MIN))
            cfg_n = 4'(DATA_BITS_MIN);
        else if (cfg_data_bits > 4'(MAX_DATA_WIDTH))
            cfg_n = 4'(MAX_DATA_WIDTH);
    end

    // Parity covers only the active data bits of the word being launched.
    always_comb begin
        data_xor = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++)
            if (4'(i) < cfg_n)
                data_xor = data_xor ^ fifo_data[i];
    end

    always_comb begin
        cfg_par    = decode_parity(cfg_parity);
        cfg_par_en = (cfg_par != PAR_NONE);
        case (cfg_par)
            PAR_EVEN: cfg_par_bit = data_xor;
            PAR_ODD:  cfg_par_bit = !data_xor;
            PAR_MARK: cfg_par_bit = 1'b1;
            default:  cfg_par_bit = 1'b0;
        endcase
    end

    // Idle and the final stop bit share one decision point so that a queued
    // word starts back-to-back without an idle bit in between.
    assign at_boundary = (state == ST_IDLE) || (state == ST_STOP2) ||
                         (state == ST_STOP1 && !frame_stop2);
    assign can_start   = !fifo_empty && !cfg_break;
    assign fifo_pop    = baud_en && at_boundary && can_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx            <= 1'b1;
            tx_done       <= 1'b0;
            cnt           <= '0;
            frame_data    <= '0;
            frame_bits    <= 4'(DATA_BITS_MIN);
            frame_par_en  <= 1'b0;
            frame_par_bit <= 1'b0;
            frame_stop2   <= 1'b0;
        end else begin
            tx_done <= baud_en && at_boundary && (state != ST_IDLE);
            if (baud_en) begin
                if (at_boundary) begin
                    if (can_start) begin
                        frame_data    <= fifo_data;
                        frame_bits    <= cfg_n;
                        frame_par_en  <= cfg_par_en;
                        frame_par_bit <= cfg_par_bit;
                        frame_stop2   <= cfg_stop2;
                        tx            <= 1'b0;
                        state         <= ST_START;
                    end else if (cfg_break) begin
                        tx    <= 1'b0;
                        state <= ST_BREAK;
                    end else begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                end else begin
                    case (state)
                        ST_START: begin
                            tx    <= frame_data[0];
                            cnt   <= '0;
                            state <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (cnt == frame_bits - 4'd1) begin
                                if (frame_par_en) begin
                                    tx    <= frame_par_bit;
                                    state <= ST_PARITY;
                                end else begin
                                    tx    <= 1'b1;
                                    state <= ST_STOP1;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                                tx  <= frame_data[cnt + 4'd1];
                            end
                        end
                        ST_PARITY: begin
                            tx    <= 1'b1;
                            state <= ST_STOP1;
                        end
                        ST_STOP1: begin
                            tx    <= 1'b1;
                            state <= ST_STOP2;
                        end
                        ST_BREAK: begin
                            if (!cfg_break) begin
                                tx    <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            tx    <= 1'b1;
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg
//   Self-checking bench: a queue-based frame model (each popped word becomes a
//   list of line bits) is advanced every clock and compared with the DUT,
//   followed by directed scenarios with literal expectations and a random run.
module tb_uart_tx_fifo_cfg;

    localparam int MAXW  = 9;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            baud_en;
    logic [MAXW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      cfg_data_bits;
    logic [2:0]      cfg_parity;
    logic            cfg_stop2;
    logic            cfg_break;
    logic            tx_flush;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;
    logic [3:0]      fifo_level;
    logic            fifo_empty;
    logic            fifo_full;

    uart_tx_fifo_cfg #(.MAX_DATA_WIDTH(MAXW), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_en       (baud_en),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .cfg_break     (cfg_break),
        .tx_flush      (tx_flush),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_level    (fifo_level),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [MAXW-1:0] q[$];      // queued words
    bit              bits[$];   // remaining line bits of the current frame
    int              m_mode;    // 0 idle, 1 frame, 2 break
    bit              m_tx = 1'b1;
    bit              m_done;
    bit              mlog[$];
    bit              dlog[$];
    int              d_done_cnt = 0;

    function automatic void start_frame(input logic [MAXW-1:0] w, input int db,
                                        input int par, input bit s2);
        int n;
        int ones;
        n = (db < 5) ? 5 : (db > MAXW) ? MAXW : db;
        ones = 0;
        bits.delete();
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            ones += w[i];
        end
        case (par)
            1: bits.push_back(bit'(ones % 2));
            2: bits.push_back(bit'((ones + 1) % 2));
            3: bits.push_back(1'b1);
            4: bits.push_back(1'b0);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        m_tx   = 1'b0;
        m_mode = 1;
    endfunction

    always @(posedge clk) begin
        int  pre_size;
        bit  b;
        b = baud_en;
        if (rst) begin
            q.delete();
            bits.delete();
            m_mode = 0;
            m_tx   = 1'b1;
            m_done = 1'b0;
        end else begin
            pre_size = q.size();
            m_done   = 1'b0;
            if (b) begin
                if (m_mode == 1 && bits.size() > 0) begin
                    m_tx = bits.pop_front();
                end else if (m_mode == 2) begin
                    if (!cfg_break) begin
                        m_tx   = 1'b1;
                        m_mode = 0;
                    end
                end else begin
                    if (m_mode == 1) m_done = 1'b1;
                    if (q.size() > 0 && !cfg_break)
                        start_frame(q.pop_front(), int'(cfg_data_bits), int'(cfg_parity), cfg_stop2);
                    else if (cfg_break) begin
                        m_mode = 2;
                        m_tx   = 1'b0;
                    end else begin
                        m_mode = 0;
                        m_tx   = 1'b1;
                    end
                end
            end
            if (tx_flush)
                q.delete();
            else if (in_valid && pre_size < DEPTH)
                q.push_back(in_data);
        end
        if (!rst && b && m_mode == 1) mlog.push_back(m_tx);
        #1;
        if (!rst && b && m_mode == 1) dlog.push_back(tx);
        if (tx_done === 1'b1) d_done_cnt++;
        chk("tx", tx, m_tx);
        chk("tx_busy", tx_busy, m_mode != 0);
        chk("tx_done", tx_done, m_done);
        chk("fifo_level", fifo_level, q.size());
        chk("fifo_empty", fifo_empty, q.size() == 0);
        chk("fifo_full", fifo_full, q.size() == DEPTH);
        chk("in_ready", in_ready, q.size() < DEPTH);
    end

    // ---------------- baud tick generator ----------------
    bit baud_rand = 1'b0;
    initial begin
        int bcnt;
        bcnt = 0;
        baud_en = 1'b0;
        forever begin
            @(negedge clk);
            if (baud_rand)
                baud_en = ($urandom_range(0, 3) == 0);
            else begin
                baud_en = (bcnt == 0);
                bcnt = (bcnt == 15) ? 0 : bcnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_logs();
        mlog.delete();
        dlog.delete();
        d_done_cnt = 0;
    endtask

    task automatic push_word(input logic [MAXW-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 6000 && !(m_mode == 0 && q.size() == 0); i++) @(negedge clk);
        if (!(m_mode == 0 && q.size() == 0)) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_log(input int n, input string name);
        int i;
        for (i = 0; i < 2000 && mlog.size() < n; i++) @(negedge clk);
        if (mlog.size() < n) chk({name, "_timeout"}, mlog.size(), n);
    endtask

    task automatic set_cfg(input int db, input int par, input bit s2);
        cfg_data_bits = 4'(db);
        cfg_parity    = 3'(par);
        cfg_stop2     = s2;
    endtask

    function automatic int log_word(input int base, input int n);
        int w;
        w = 0;
        for (int i = 0; i < n; i++)
            if (base + 1 + i < dlog.size()) w |= int'(dlog[base + 1 + i]) << i;
        return w;
    endfunction

    // ---------------- directed + random stimulus ----------------
    int exp_a[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int ptab[4][6] = '{
        '{7, 1, 1, 'h55, 0, 11},
        '{5, 2, 0, 'h1F, 0, 8},
        '{8, 3, 0, 'h00, 1, 11},
        '{8, 4, 0, 'hFF, 0, 11}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_flush = 1'b0; cfg_break = 1'b0;
        set_cfg(8, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0xA5
        clear_logs();
        push_word(9'h0A5);
        wait_idle("8n1");
        chk("8n1_len", dlog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < dlog.size()) chk("8n1_bit", dlog[i], exp_a[i]);
            if (i < mlog.size()) chk("8n1_model_bit", mlog[i], exp_a[i]);
        end
        chk("8n1_done_cnt", d_done_cnt, 1);

        // parity and stop-bit variants
        for (int t = 0; t < 4; t++) begin
            set_cfg(ptab[t][0], ptab[t][1], ptab[t][2] != 0);
            @(negedge clk);
            clear_logs();
            push_word(9'(ptab[t][3]));
            wait_idle("par");
            chk("par_len", dlog.size(), ptab[t][5]);
            if (dlog.size() > ptab[t][0] + 1) chk("par_bit", dlog[ptab[t][0] + 1], ptab[t][4]);
            if (mlog.size() > ptab[t][0] + 1) chk("par_model_bit", mlog[ptab[t][0] + 1], ptab[t][4]);
        end

        // fill FIFO behind a break, then drain back-to-back
        set_cfg(8, 0, 0);
        cfg_break = 1'b1;
        for (int i = 0; i < 100 && m_mode != 2; i++) @(negedge clk);
        chk("break_entered", tx_busy, 1);
        chk("break_line", tx, 0);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(8'h10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_level", fifo_level, 8);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_full", fifo_full, 1);
        clear_logs();
        cfg_break = 1'b0;
        wait_idle("drain");
        chk("drain_done_cnt", d_done_cnt, 8);
        chk("drain_len", dlog.size(), 80);
        chk("drain_level", fifo_level, 0);
        chk("drain_first_word", log_word(0, 8), 'h10);
        chk("drain_last_word", log_word(70, 8), 'h17);

        // config change mid-frame
        clear_logs();
        push_word(9'h0FF);
        push_word(9'h03F);
        wait_log(3, "midcfg");
        cfg_data_bits = 4'd5;
        wait_idle("midcfg");
        chk("midcfg_len", dlog.size(), 17);
        chk("midcfg_done_cnt", d_done_cnt, 2);
        set_cfg(8, 0, 0);

        // reset in the DATA state
        clear_logs();
        push_word(9'h05A);
        push_word(9'h033);
        push_word(9'h044);
        wait_log(4, "rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_done", tx_done, 0);
        repeat (40) @(negedge clk);
        chk("rst_no_done", d_done_cnt, 0);

        // flush while sending
        clear_logs();
        push_word(9'h0C3);
        push_word(9'h011);
        push_word(9'h022);
        wait_log(2, "flush");
        tx_flush = 1'b1;
        @(negedge clk);
        tx_flush = 1'b0;
        chk("flush_level", fifo_level, 0);
        wait_idle("flush");
        chk("flush_len", dlog.size(), 10);
        chk("flush_done_cnt", d_done_cnt, 1);
        chk("flush_word", log_word(0, 8), 'hC3);

        // randomized run
        baud_rand = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            in_valid      = $urandom_range(0, 1) == 1;
            in_data       = 9'($urandom);
            cfg_data_bits = 4'($urandom_range(0, 15));
            cfg_parity    = 3'($urandom_range(0, 7));
            cfg_stop2     = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) cfg_break = !cfg_break;
            tx_flush      = $urandom_range(0, 99) == 0;
            rst           = $urandom_range(0, 499) == 0;
            @(negedge clk);
        end
        in_valid = 1'b0; tx_flush = 1'b0; rst = 1'b0; cfg_break = 1'b0;
        wait_idle("random_drain");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
